// File: rtl/render_sequencer.sv
// render_sequencer: frame-level scheduler for the single pixel-write port.
// Each accepted frame tick snapshots ball/plate geometry, erases the previous
// ball and plate, draws the new ones, then lends the port to the scoreboard
// drawer until it signals done. All outputs are registered.
module render_sequencer #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned PLATE_H     = 2,
  parameter logic [2:0]  BG_COLOR    = 3'b000,
  parameter logic [2:0]  BALL_COLOR  = 3'b111,
  parameter logic [2:0]  PLATE_COLOR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] ballx,
  input  logic [6:0] bally,
  input  logic [5:0] ballsize,
  input  logic [7:0] platex,
  input  logic [6:0] platey,
  input  logic [5:0] platesize,
  input  logic       score_done,
  input  logic [7:0] score_x,
  input  logic [6:0] score_y,
  input  logic [2:0] score_color,
  input  logic       score_plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       score_req,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, ERASE_BALL, ERASE_PLATE, DRAW_BALL, DRAW_PLATE, SCORE
  } state_t;

  typedef struct packed {
    logic [7:0] ball_x;
    logic [6:0] ball_y;
    logic [5:0] ball_size;
    logic [7:0] plate_x;
    logic [6:0] plate_y;
    logic [5:0] plate_size;
  } geom_t;

  typedef struct packed {
    logic [7:0] bx;
    logic [6:0] by;
    logic [5:0] w;
    logic [5:0] h;
    logic [2:0] col;
  } rect_t;

  localparam logic [5:0] PLATE_H_6  = 6'(PLATE_H);
  localparam logic [8:0] SCREEN_W_9 = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H_8 = 8'(SCREEN_H);

  // Rectangle (origin, size, colour) painted in a given state.
  function automatic rect_t rect_of(state_t s, geom_t o, geom_t n);
    rect_t r;
    r = '0;
    case (s)
      ERASE_BALL:  r = '{o.ball_x,  o.ball_y,  o.ball_size,  o.ball_size, BG_COLOR};
      ERASE_PLATE: r = '{o.plate_x, o.plate_y, o.plate_size, PLATE_H_6,   BG_COLOR};
      DRAW_BALL:   r = '{n.ball_x,  n.ball_y,  n.ball_size,  n.ball_size, BALL_COLOR};
      DRAW_PLATE:  r = '{n.plate_x, n.plate_y, n.plate_size, PLATE_H_6,   PLATE_COLOR};
      default:     r = '0;
    endcase
    return r;
  endfunction

  // Fixed order of the pixel phases; everything after the plate is SCORE.
  function automatic state_t succ(state_t s);
    case (s)
      ERASE_BALL:  return ERASE_PLATE;
      ERASE_PLATE: return DRAW_BALL;
      DRAW_BALL:   return DRAW_PLATE;
      default:     return SCORE;
    endcase
  endfunction

  // Advance past empty rectangles so a zero-sized object costs no cycles.
  function automatic state_t skip_empty(state_t s, geom_t o, geom_t n);
    state_t t;
    rect_t  r;
    t = s;
    for (int i = 0; i < 4; i++) begin
      r = rect_of(t, o, n);
      if (t != SCORE && (r.w == 6'd0 || r.h == 6'd0)) t = succ(t);
    end
    return t;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] cx_q, cx_d, cy_q, cy_d;
  logic       valid_q, valid_d;
  geom_t      new_q, new_d, old_q, old_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic       plot_q, plot_d, score_req_q, score_req_d;
  logic       busy_q, busy_d, overrun_q, overrun_d;

  geom_t      tick_geom;
  rect_t      cur, nxt;
  logic [8:0] px;
  logic [7:0] py;

  assign tick_geom = '{ballx, bally, ballsize, platex, platey, platesize};

  // Next-state, counter and output computation; outputs describe the state being entered.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    valid_d     = valid_q;
    new_d       = new_q;
    old_d       = old_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    plot_d      = 1'b0;
    overrun_d   = frame_tick && (state_q != IDLE);
    cur         = rect_of(state_q, old_q, new_q);
    nxt         = '0;
    px          = '0;
    py          = '0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          new_d   = tick_geom;
          state_d = skip_empty(valid_q ? ERASE_BALL : DRAW_BALL, old_q, tick_geom);
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      SCORE: begin
        if (score_done) state_d = IDLE;
      end
      default: begin
        if (cx_q == cur.w - 6'd1) begin
          cx_d = '0;
          if (cy_q == cur.h - 6'd1) begin
            cy_d    = '0;
            state_d = skip_empty(succ(state_q), old_q, new_q);
          end else begin
            cy_d = cy_q + 6'd1;
          end
        end else begin
          cx_d = cx_q + 6'd1;
        end
      end
    endcase

    // Frame geometry becomes the next frame's erase target once drawing is done.
    if (state_d == SCORE && state_q != SCORE) begin
      old_d   = new_d;
      valid_d = 1'b1;
    end

    if (state_q == SCORE) begin
      x_d     = score_x;
      y_d     = score_y;
      color_d = score_color;
      plot_d  = score_plot;
    end else if (state_d != IDLE && state_d != SCORE) begin
      nxt     = rect_of(state_d, old_q, new_d);
      px      = {1'b0, nxt.bx} + {3'b000, cx_d};
      py      = {1'b0, nxt.by} + {2'b00, cy_d};
      x_d     = px[7:0];
      y_d     = py[6:0];
      color_d = nxt.col;
      plot_d  = (px < SCREEN_W_9) && (py < SCREEN_H_8);
    end

    score_req_d = (state_d == SCORE);
    busy_d      = (state_d != IDLE);
  end

  // Control FSM and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= '0;
      plot_q      <= 1'b0;
      score_req_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      plot_q      <= plot_d;
      score_req_q <= score_req_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Geometry snapshots; only read while valid_q or after a tick has loaded them.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are deliberately unreset; valid_q guards every use of old_q.
    new_q <= new_d;
    old_q <= old_d;
  end

  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign plot      = plot_q;
  assign score_req = score_req_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Scoreboard bench for render_sequencer: frame stimulus pushes expected pixels,
// an independent monitor pops one entry for every plotted pixel.
module tb_render_sequencer;

  logic       clk = 1'b0;
  logic       reset, frame_tick;
  logic [7:0] ballx, platex, score_x;
  logic [6:0] bally, platey, score_y;
  logic [5:0] ballsize, platesize;
  logic       score_done, score_plot;
  logic [2:0] score_color;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, score_req, busy, overrun;

  typedef struct packed { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  pix_t exp_q[$];

  int vectors = 0, miscompares = 0, plot_cnt = 0;

  // bench-side memory of the last completed frame geometry
  logic       m_valid = 1'b0;
  logic [7:0] m_bx, m_px;
  logic [6:0] m_by, m_py;
  logic [5:0] m_bs, m_ps;

  render_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ballx(ballx), .bally(bally), .ballsize(ballsize),
    .platex(platex), .platey(platey), .platesize(platesize),
    .score_done(score_done), .score_x(score_x), .score_y(score_y),
    .score_color(score_color), .score_plot(score_plot),
    .x(x), .y(y), .color(color), .plot(plot),
    .score_req(score_req), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rect(input int bx, input int by, input int w, input int h, input logic [2:0] c);
    pix_t p;
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        if (bx + i < 160 && by + j < 120) begin
          p.x = 8'(bx + i);
          p.y = 7'(by + j);
          p.c = c;
          exp_q.push_back(p);
        end
  endtask

  // Monitor: every plotted pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    pix_t e;
    if (plot === 1'b1) begin
      plot_cnt++;
      check("x_on_screen", {31'd0, x < 8'd160}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_plot", {14'd0, x, y, color}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {14'd0, x, y, color}, {14'd0, e});
      end
    end
  end

  task automatic scramble();
    ballx = ~ballx; bally = ~bally; ballsize = ~ballsize;
    platex = ~platex; platey = ~platey; platesize = ~platesize;
  endtask

  // One frame: tick, pixel phases, optional mid-frame tick or reset, score handshake.
  task automatic run_frame(input string name,
                           input logic [7:0] bx, input logic [6:0] by, input logic [5:0] bs,
                           input logic [7:0] px, input logic [6:0] py, input logic [5:0] ps,
                           input logic [7:0] fx, input logic [6:0] fy, input logic [2:0] fc,
                           input int exp_n, input int exp_plots,
                           input int tick_at, input int reset_at,
                           input int n_score, input bit ovr_exit);
    int n;
    bit stop;
    if (m_valid) begin
      push_rect(m_bx, m_by, m_bs, m_bs, 3'b000);
      push_rect(m_px, m_py, m_ps, 2, 3'b000);
    end
    push_rect(bx, by, bs, bs, 3'b111);
    push_rect(px, py, ps, 2, 3'b010);
    plot_cnt = 0;
    ballx = bx; bally = by; ballsize = bs;
    platex = px; platey = py; platesize = ps;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    scramble();
    n = 1;
    stop = 1'b0;
    while (!stop) begin
      if (n == 1) check({name, "_first_pixel"}, {13'd0, plot, x, y, fc == color ? fc : color},
                        {13'd0, 1'b1, fx, fy, fc});
      if (tick_at != 0 && n == tick_at + 1) check({name, "_overrun_pulse"}, {31'd0, overrun}, 32'd1);
      if (tick_at != 0 && n == tick_at + 2) check({name, "_overrun_single"}, {31'd0, overrun}, 32'd0);
      if (reset_at != 0 && n == reset_at + 1) begin
        check({name, "_reset_abort"}, {11'd0, plot, busy, score_req, x, y, color}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        return;
      end
      if (score_req === 1'b1) begin
        stop = 1'b1;
      end else if (n > exp_n + 4) begin
        check({name, "_score_req_timeout"}, n, exp_n);
        return;
      end else begin
        frame_tick = (tick_at != 0 && n == tick_at);
        reset      = (reset_at != 0 && n == reset_at);
        @(negedge clk);
        frame_tick = 1'b0;
        n++;
      end
    end
    check({name, "_frame_cycles"}, n, exp_n);
    check({name, "_frame_plots"}, plot_cnt, exp_plots);
    check({name, "_draw_drained"}, exp_q.size(), 0);
    check({name, "_score_entry"}, {30'd0, busy, plot}, 32'd2);

    if (n_score == 0) begin
      score_plot = 1'b0;
      score_done = 1'b1;
      @(negedge clk);
    end else begin
      for (int i = 0; i < n_score; i++) begin
        pix_t p;
        score_x = 8'(10 + i); score_y = 7'(5 + 2 * i); score_color = 3'(i + 1);
        score_plot = 1'b1;
        score_done = (i == n_score - 1);
        frame_tick = ovr_exit && (i == n_score - 1);
        p.x = score_x; p.y = score_y; p.c = score_color;
        exp_q.push_back(p);
        @(negedge clk);
      end
    end
    score_done = 1'b0;
    score_plot = 1'b0;
    frame_tick = 1'b0;
    check({name, "_score_req_drop"}, {30'd0, score_req, overrun}, {30'd0, 1'b0, ovr_exit});
    @(negedge clk);
    check({name, "_idle_after"}, {30'd0, busy, plot}, 32'd0);
    check({name, "_score_drained"}, exp_q.size(), 0);
    m_valid = 1'b1;
    m_bx = bx; m_by = by; m_bs = bs;
    m_px = px; m_py = py; m_ps = ps;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    ballx = '0; bally = '0; ballsize = '0; platex = '0; platey = '0; platesize = '0;
    score_done = 1'b0; score_x = '0; score_y = '0; score_color = '0; score_plot = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {11'd0, x, y, color, plot, score_req, busy, overrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // first frame after reset: no erase, 25 ball + 20 plate plots
    run_frame("f1", 8'd110, 7'd0, 6'd5, 8'd100, 7'd100, 6'd10,
              8'd110, 7'd0, 3'b111, 46, 45, 0, 0, 0, 1'b0);
    // erase previous, redraw; three score pixels, tick on the exit cycle is overrun
    run_frame("f2", 8'd120, 7'd0, 6'd5, 8'd100, 7'd100, 6'd10,
              8'd110, 7'd0, 3'b000, 91, 90, 0, 0, 3, 1'b1);

    // score_plot outside SCORE must not reach the port
    score_plot = 1'b1; score_x = 8'd3; score_y = 7'd3; score_color = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_score_leak", {31'd0, plot}, 32'd0);
    end

    // clipping at the right and bottom edges, score_plot still held high
    run_frame("f3", 8'd158, 7'd0, 6'd5, 8'd100, 7'd119, 6'd10,
              8'd120, 7'd0, 3'b000, 91, 65, 0, 0, 1, 1'b0);
    // tick during DRAW_PLATE is an overrun and must not re-latch geometry
    run_frame("f4", 8'd30, 7'd40, 6'd3, 8'd50, 7'd60, 6'd4,
              8'd158, 7'd0, 3'b000, 63, 37, 57, 0, 0, 1'b0);
    // erase uses f4 geometry; reset lands in ERASE_PLATE
    run_frame("f5", 8'd60, 7'd70, 6'd2, 8'd0, 7'd0, 6'd3,
              8'd30, 7'd40, 3'b000, 18, 17, 0, 12, 0, 1'b0);
    @(negedge clk);
    // after reset: no erase, zero-size ball skipped, plate starts immediately
    run_frame("f6", 8'd10, 7'd10, 6'd0, 8'd20, 7'd30, 6'd4,
              8'd20, 7'd30, 3'b010, 9, 8, 0, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
